// File: rtl/preamble_correlator_banked.sv
// preamble_correlator_banked: multi-rate preamble correlator for a 1-bit sliced
// sample stream. One shared sample history feeds BANKS correlator banks. Each bank
// uses its own chip period. It majority-votes every chip window and counts how many
// chips agree with PATTERN. An all-zeros flag rides the same pipeline as the scores.
// Pipeline: history shift -> per-chip majority -> match sum / zero reduce.

// One correlator bank. Its chip period is fixed at elaboration time.
module preamble_corr_bank #(
  parameter int                LENGTH     = 4,
  parameter int                PERIOD     = 5,
  parameter logic [LENGTH-1:0] PATTERN    = '0,
  parameter int                CORR_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LENGTH*PERIOD-1:0] win,
  input  logic                     chip_en,
  input  logic                     sum_en,
  output logic [CORR_WIDTH-1:0]    score
);
  localparam int PCW = $clog2(PERIOD + 1) + 1;
  localparam logic [PCW:0] PER_W = PERIOD[PCW:0];

  logic [LENGTH-1:0]     chip_d;
  logic [LENGTH-1:0]     chip_q;
  logic [CORR_WIDTH-1:0] score_d;

  // Strict majority: a tie resolves to 0, so an all-zero window also decides 0.
  function automatic logic majority(input logic [PERIOD-1:0] w);
    logic [PCW-1:0] ones;
    ones = '0;
    for (int i = 0; i < PERIOD; i++) ones = ones + PCW'(w[i]);
    return {ones, 1'b0} > PER_W;
  endfunction

  // Chip j holds window bits [j*PERIOD +: PERIOD]. Bit 0 of the window is the
  // newest sample, so chip LENGTH-1 is the oldest chip and pairs with the pattern MSB.
  for (genvar j = 0; j < LENGTH; j++) begin : g_chip
    assign chip_d[j] = majority(win[j*PERIOD +: PERIOD]);
  end

  // Count the chips that agree with the pattern.
  always_comb begin
    score_d = '0;
    for (int j = 0; j < LENGTH; j++)
      score_d = score_d + CORR_WIDTH'(chip_q[j] ~^ PATTERN[j]);
  end

  // Stage 2: capture the chip decisions for the sample that just shifted in.
  always_ff @(posedge clk or negedge rst)
    if (!rst)         chip_q <= '0;
    else if (chip_en) chip_q <= chip_d;

  // Stage 3: capture the score. It holds between accepted samples.
  always_ff @(posedge clk or negedge rst)
    if (!rst)        score <= '0;
    else if (sum_en) score <= score_d;
endmodule

// Top level: shared history, the bank array, the zero detector and the valid pipe.
module preamble_correlator_banked #(
  parameter  int                LENGTH       = 4,
  parameter  int                BANKS        = 4,
  parameter  int                SCALING_BITS = 5,
  parameter  logic [LENGTH-1:0] PATTERN      = 4'b1010,
  localparam int                CORR_WIDTH   = $clog2(LENGTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_dat,
  input  logic                        in_vld,
  output logic [BANKS*CORR_WIDTH-1:0] corr_dat,
  output logic                        corr_vld,
  output logic                        all_zeros
);
  localparam int PMAX   = SCALING_BITS + BANKS - 1;  // longest chip period
  localparam int H      = LENGTH * PMAX;             // history depth
  localparam int STAGES = 3;

  logic [STAGES:1]                    vld_q;
  logic [STAGES:0]                    vld_pipe;
  logic [H-1:0]                       hist;
  logic [LENGTH-1:0]                  nz_grp;
  logic [BANKS-1:0][CORR_WIDTH-1:0]   score;

  assign vld_pipe  = {vld_q, in_vld};
  assign corr_vld  = vld_pipe[STAGES];
  assign corr_dat  = score;

  // The valid shift register walks each accepted sample through the three stages.
  always_ff @(posedge clk or negedge rst)
    if (!rst) vld_q <= '0;
    else      vld_q <= vld_pipe[STAGES-1:0];

  // Stage 1: sample history. hist[0] is the newest sample. Unfilled slots stay 0.
  always_ff @(posedge clk or negedge rst)
    if (!rst)        hist <= '0;
    else if (in_vld) hist <= {hist[H-2:0], in_dat};

  // Stage 2: partial OR per longest-period chip group. It keeps the final zero
  // reduce small.
  always_ff @(posedge clk or negedge rst)
    if (!rst) nz_grp <= '0;
    else if (vld_pipe[1])
      for (int j = 0; j < LENGTH; j++) nz_grp[j] <= |hist[j*PMAX +: PMAX];

  // Stage 3: loss-of-signal flag. It is aligned with the bank scores.
  always_ff @(posedge clk or negedge rst)
    if (!rst)             all_zeros <= 1'b1;
    else if (vld_pipe[2]) all_zeros <= ~|nz_grp;

  // Bank b looks at the newest LENGTH*(SCALING_BITS+b) samples.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    localparam int P = SCALING_BITS + b;
    preamble_corr_bank #(
      .LENGTH    (LENGTH),
      .PERIOD    (P),
      .PATTERN   (PATTERN),
      .CORR_WIDTH(CORR_WIDTH)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .win    (hist[LENGTH*P-1:0]),
      .chip_en(vld_pipe[1]),
      .sum_en (vld_pipe[2]),
      .score  (score[b])
    );
  end
endmodule

// File: tb/tb_preamble_correlator_banked.sv
// Bench for preamble_correlator_banked. A monitor checks every cycle against a
// queue-based model of the sample stream. Table vectors and hand sequences check
// fixed scores.
module tb_preamble_correlator_banked;
  localparam int L  = 4;
  localparam int NB = 4;
  localparam int SB = 5;
  localparam int CW = 3;
  localparam int H  = L * (SB + NB - 1);

  logic              clk;
  logic              rst;
  logic              in_dat;
  logic              in_vld;
  logic [NB*CW-1:0]  corr_dat;
  logic              corr_vld;
  logic              all_zeros;

  preamble_correlator_banked dut (
    .clk      (clk),
    .rst      (rst),
    .in_dat   (in_dat),
    .in_vld   (in_vld),
    .corr_dat (corr_dat),
    .corr_vld (corr_vld),
    .all_zeros(all_zeros)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  logic mon_en = 1'b0;
  logic [3:0] pat = 4'b1010;

  typedef struct { int edge_no; logic [NB*CW-1:0] dat; logic z; } exp_t;
  exp_t exp_q[$];
  logic [NB*CW-1:0] held_dat = '0;
  logic held_z = 1'b1;
  bit samp_q[$];  // every accepted sample since reset, oldest first

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: window = last L*P samples (missing ones are 0), chip k oldest first.
  function automatic int model_bank(input int b);
    int p, n, score, ones, idx;
    p = SB + b;
    n = samp_q.size();
    score = 0;
    for (int k = 0; k < L; k++) begin
      ones = 0;
      for (int i = 0; i < p; i++) begin
        idx = n - L*p + k*p + i;
        if (idx >= 0 && samp_q[idx]) ones++;
      end
      if ((2*ones > p) == pat[L-1-k]) score++;
    end
    return score;
  endfunction

  function automatic logic model_zero();
    int n;
    n = samp_q.size();
    for (int i = n - H; i < n; i++)
      if (i >= 0 && samp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NB*CW-1:0] model_dat();
    logic [NB*CW-1:0] r;
    int s;
    r = '0;
    for (int b = 0; b < NB; b++) begin
      s = model_bank(b);
      r[b*CW +: CW] = s[CW-1:0];
    end
    return r;
  endfunction

  // Every-cycle check: a pulse exactly when due, otherwise held outputs.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
        chk("mon_late", edge_cnt, exp_q[0].edge_no);
        exp_q.delete(0);
      end
      if (exp_q.size() > 0 && exp_q[0].edge_no == edge_cnt) begin
        held_dat = exp_q[0].dat;
        held_z   = exp_q[0].z;
        exp_q.delete(0);
        chk("mon_vld", corr_vld, 1);
      end else begin
        chk("mon_vld", corr_vld, 0);
      end
      chk("mon_dat", corr_dat, held_dat);
      chk("mon_zero", all_zeros, held_z);
    end
  end

  // All driving tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic d);
    exp_t e;
    in_vld = 1'b1;
    in_dat = d;
    samp_q.push_back(d);
    e.edge_no = edge_cnt + 3;
    e.dat = model_dat();
    e.z = model_zero();
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_vld"}, corr_vld, 0);
    chk({nm, "_dat"}, corr_dat, 0);
    chk({nm, "_zero"}, all_zeros, 1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    in_vld = 1'b0;
    in_dat = 1'b0;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk_reset_vals("rst_hold");
    samp_q.delete();
    exp_q.delete();
    held_dat = '0;
    held_z = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("rst_rel");
    mon_en = 1'b1;
  endtask

  // Run-length stream: n samples in alternating runs of length run.
  task automatic send_runs(input int run, input bit first, input int n);
    for (int s = 0; s < n; s++) send(first ^ bit'((s / run) % 2));
  endtask

  typedef struct { int run; bit first; int n; int bank; int exp_score; bit exp_z; } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{5, 1'b1, 20, 0, 4, 1'b0};  // bank 0 full match
    vecs[1] = '{6, 1'b1, 24, 1, 4, 1'b0};  // bank 1 full match
    vecs[2] = '{7, 1'b1, 28, 2, 4, 1'b0};  // bank 2 full match
    vecs[3] = '{8, 1'b1, 32, 3, 4, 1'b0};  // bank 3 full match
    vecs[4] = '{8, 1'b1, 32, 0, 1, 1'b0};  // bank 0 sees only the last chip
    vecs[5] = '{5, 1'b0, 20, 0, 0, 1'b0};  // inverted preamble
    vecs[6] = '{40, 1'b1, 32, 2, 2, 1'b0}; // all ones
    vecs[7] = '{40, 1'b0, 32, 3, 2, 1'b1}; // all zeros

    rst = 1'b0;
    in_vld = 1'b0;
    in_dat = 1'b0;

    // Reset values, then first-sample latency and the empty-history score.
    do_reset();
    send(1'b0);
    idle(1);
    chk("first_vld_early", corr_vld, 0);
    idle(1);
    chk("first_vld", corr_vld, 1);
    chk("first_dat", corr_dat, 12'b010_010_010_010);
    chk("first_zero", all_zeros, 1);
    idle(3);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      send_runs(vecs[i].run, vecs[i].first, vecs[i].n);
      idle(4);
      chk($sformatf("vec%0d_score", i), corr_dat[vecs[i].bank*CW +: CW], vecs[i].exp_score);
      chk($sformatf("vec%0d_zero", i), all_zeros, vecs[i].exp_z);
    end

    // Bank-0 preamble with idle gaps between samples.
    do_reset();
    for (int s = 0; s < 20; s++) begin
      send(bit'(((s / 5) % 2) == 0));
      idle($urandom_range(0, 3));
    end
    idle(4);
    chk("gap_bank0", corr_dat[0 +: CW], 4);

    // Loss of signal. The last '1' of the preamble is 5 samples back, so it ages
    // out of the 32-sample history on the 27th zero.
    for (int s = 0; s < 26; s++) send(1'b0);
    idle(4);
    chk("los_26", all_zeros, 0);
    send(1'b0);
    idle(4);
    chk("los_27", all_zeros, 1);
    for (int s = 0; s < 5; s++) send(1'b0);
    idle(4);
    chk("los_32", all_zeros, 1);
    send(1'b1);
    idle(4);
    chk("los_one", all_zeros, 0);

    // Reset mid-stream while samples are still in flight, then replay.
    do_reset();
    send_runs(8, 1'b1, 15);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_vals("mid_rst");
    do_reset();
    send_runs(8, 1'b1, 32);
    idle(4);
    chk("replay_bank3", corr_dat[3*CW +: CW], 4);
    chk("replay_bank0", corr_dat[0 +: CW], 1);

    // Random runs with random gaps. The monitor checks each cycle against the model.
    do_reset();
    for (int r = 0; r < 60; r++) begin
      bit v;
      int len;
      v = bit'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int s = 0; s < len; s++) begin
        send(v);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(5);
    chk("rand_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
